// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - round-robin arbiter granting four requesters a registered bitwise op
module gate_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [7:0]           op_flat,
    input  logic [4*WIDTH-1:0]   a_flat,
    input  logic [4*WIDTH-1:0]   b_flat,
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic [WIDTH-1:0]     res,
    output logic                 res_valid,
    output logic [1:0]           res_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         ptr;
    logic [1:0]         idx;
    logic [1:0]         sel;
    logic [1:0]         cand;
    logic               found;
    logic [1:0]         op_l;
    logic [WIDTH-1:0]   a_l;
    logic [WIDTH-1:0]   b_l;
    logic [WIDTH-1:0]   op_res;

    // Walk downward so the requester closest above ptr overwrites the others.
    always_comb begin
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_res = '0;
        case (op_l)
            2'b00:   op_res = a_l | b_l;
            2'b01:   op_res = a_l & b_l;
            2'b10:   op_res = a_l ^ b_l;
            default: op_res = ~(a_l | b_l);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are captured at the grant edge so later input changes cannot disturb the op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= 2'd0;
            idx       <= 2'd0;
            gnt       <= 4'd0;
            op_l      <= 2'd0;
            a_l       <= '0;
            b_l       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            res_id    <= 2'd0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt  <= 4'b0001 << sel;
                        idx  <= sel;
                        op_l <= op_flat[{sel, 1'b0} +: 2];
                        a_l  <= a_flat[int'(sel)*WIDTH +: WIDTH];
                        b_l  <= b_flat[int'(sel)*WIDTH +: WIDTH];
                    end
                end
                EXEC: begin
                    res <= op_res;
                end
                RESP: begin
                    res_valid <= 1'b1;
                    res_id    <= idx;
                    ptr       <= idx + 2'd1;
                    gnt       <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_gate_arbiter.sv
// tb/tb_gate_arbiter.sv - self-checking bench for gate_arbiter against a behavioural model
module tb_gate_arbiter;

    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [7:0]       op_flat;
    logic [4*W-1:0]   a_flat;
    logic [4*W-1:0]   b_flat;
    logic [3:0]       gnt;
    logic             busy;
    logic [W-1:0]     res;
    logic             res_valid;
    logic [1:0]       res_id;

    int vectors;
    int miscompares;

    // Model: phase counts remaining cycles of the current operation (2 = computing, 1 = responding).
    int           m_phase;
    int           m_ptr;
    int           m_idx;
    logic [1:0]   m_op;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [W-1:0] m_res;
    logic [3:0]   m_gnt;
    logic         m_rv;
    logic [1:0]   m_rid;

    gate_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_flat(op_flat),
        .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt), .busy(busy),
        .res(res), .res_valid(res_valid), .res_id(res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int ones;
        for (int i = 0; i < W; i++) begin
            ones = int'(a[i]) + int'(b[i]);
            case (op)
                2'b00:   r[i] = (ones > 0);
                2'b01:   r[i] = (ones == 2);
                2'b10:   r[i] = (ones == 1);
                default: r[i] = (ones == 0);
            endcase
        end
        return r;
    endfunction

    function automatic logic [W+7:0] exp_out();
        return {m_gnt, (m_phase != 0), m_rv, m_rid, m_res};
    endfunction

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_idx = 0; m_gnt = 0; m_rv = 0; m_rid = 0; m_res = 0;
            return;
        end
        m_rv = 1'b0;
        if (m_phase == 0) begin
            w = -1;
            for (int k = 3; k >= 0; k--)
                if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w >= 0) begin
                m_idx   = w;
                m_gnt   = 4'(1 << w);
                m_op    = op_flat[2*w +: 2];
                m_a     = a_flat[w*W +: W];
                m_b     = b_flat[w*W +: W];
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_res   = ref_op(m_op, m_a, m_b);
            m_phase = 1;
        end else begin
            m_rv    = 1'b1;
            m_rid   = 2'(m_idx);
            m_ptr   = (m_idx + 1) % 4;
            m_gnt   = 4'd0;
            m_phase = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        vectors++;
        if ({gnt, busy, res_valid, res_id, res} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state actual=%h required=%h", {gnt, busy, res_valid, res_id, res}, 16'h0000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        op_flat[1:0] = 2'b00; a_flat[7:0] = 8'hA5; b_flat[7:0] = 8'h0F; req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            cycle();
            vectors++;
            if ({gnt, busy, res_valid, res_id, res} !== exp_out()) begin
                miscompares++;
                $display("FAIL single_model c=%0d actual=%h required=%h", c, {gnt, busy, res_valid, res_id, res}, exp_out());
            end
            if (c < 2) begin
                vectors++;
                if (gnt !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL single_gnt c=%0d actual=%b required=0001", c, gnt);
                end
            end
            if (c == 2) begin
                vectors++;
                if ({res_valid, res_id, res, gnt} !== {1'b1, 2'd0, 8'hAF, 4'b0000}) begin
                    miscompares++;
                    $display("FAIL single_result actual rv=%b id=%0d res=%h gnt=%b required rv=1 id=0 res=af gnt=0000",
                             res_valid, res_id, res, gnt);
                end
                req = 4'b0000;
            end
        end
    endtask

    task automatic test_ops();
        logic [7:0] want [3] = '{8'h30, 8'hCC, 8'h03};
        for (int j = 0; j < 3; j++) begin
            op_flat[5:4] = 2'(j + 1); a_flat[23:16] = 8'hF0; b_flat[23:16] = 8'h3C; req = 4'b0100;
            for (int c = 0; c < 3; c++) begin
                cycle();
                vectors++;
                if ({gnt, busy, res_valid, res_id, res} !== exp_out()) begin
                    miscompares++;
                    $display("FAIL ops_model op=%0d c=%0d actual=%h required=%h", j + 1, c, {gnt, busy, res_valid, res_id, res}, exp_out());
                end
            end
            vectors++;
            if ({res_valid, res_id, res} !== {1'b1, 2'd2, want[j]}) begin
                miscompares++;
                $display("FAIL ops_result op=%0d actual rv=%b id=%0d res=%h required rv=1 id=2 res=%h", j + 1, res_valid, res_id, res, want[j]);
            end
            req = 4'b0000;
            cycle();
        end
    endtask

    task automatic test_rotation();
        int n = 0;
        int last = -10;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        a_flat = {$urandom, $urandom}; b_flat = {$urandom, $urandom}; op_flat = 8'($urandom);
        req = 4'b1111;
        for (int c = 0; c < 24; c++) begin
            cycle();
            vectors++;
            if ({gnt, busy, res_valid, res_id, res} !== exp_out()) begin
                miscompares++;
                $display("FAIL rotation_model c=%0d actual=%h required=%h", c, {gnt, busy, res_valid, res_id, res}, exp_out());
            end
            if (res_valid === 1'b1) begin
                vectors++;
                if (res_id !== 2'(n % 4) || (n > 0 && c - last != 3)) begin
                    miscompares++;
                    $display("FAIL rotation_order n=%0d actual id=%0d gap=%0d required id=%0d gap=3", n, res_id, c - last, n % 4);
                end
                last = c;
                n++;
            end
        end
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL rotation_count actual=%0d required=8", n);
        end
    endtask

    task automatic test_skip();
        logic [3:0] reqs [2] = '{4'b1010, 4'b1000};
        logic [3:0] gnts [2] = '{4'b0010, 4'b1000};
        for (int j = 0; j < 2; j++) begin
            req = reqs[j];
            for (int c = 0; c < 3; c++) begin
                cycle();
                vectors++;
                if ({gnt, busy, res_valid, res_id, res} !== exp_out()) begin
                    miscompares++;
                    $display("FAIL skip_model j=%0d c=%0d actual=%h required=%h", j, c, {gnt, busy, res_valid, res_id, res}, exp_out());
                end
                if (c == 0) begin
                    vectors++;
                    if (gnt !== gnts[j]) begin
                        miscompares++;
                        $display("FAIL skip_gnt j=%0d actual=%b required=%b", j, gnt, gnts[j]);
                    end
                end
            end
        end
        req = 4'b0000;
        cycle();
    endtask

    task automatic test_latch();
        op_flat[3:2] = 2'b10; a_flat[15:8] = 8'h5A; b_flat[15:8] = 8'hFF; req = 4'b0010;
        cycle();
        a_flat[15:8] = 8'h00; b_flat[15:8] = 8'h00; op_flat[3:2] = 2'b00; req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            cycle();
            vectors++;
            if ({gnt, busy, res_valid, res_id, res} !== exp_out()) begin
                miscompares++;
                $display("FAIL latch_model c=%0d actual=%h required=%h", c, {gnt, busy, res_valid, res_id, res}, exp_out());
            end
        end
        vectors++;
        if ({res_valid, res_id, res} !== {1'b1, 2'd1, 8'hA5}) begin
            miscompares++;
            $display("FAIL latch_result actual rv=%b id=%0d res=%h required rv=1 id=1 res=a5", res_valid, res_id, res);
        end
        cycle();
    endtask

    task automatic test_reset_exec();
        req = 4'b0001;
        cycle();
        req = 4'b0000; rst_n = 1'b0;
        cycle();
        vectors++;
        if ({gnt, busy, res_valid, res_id, res} !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_state actual=%h required=0000", {gnt, busy, res_valid, res_id, res});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            vectors++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_valid c=%0d actual rv=%b busy=%b required rv=0 busy=0", c, res_valid, busy);
            end
        end
        req = 4'b0100;
        cycle();
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL abort_regrant actual=%b required=0100", gnt);
        end
        cycle();
        cycle();
        vectors++;
        if ({res_valid, res_id} !== {1'b1, 2'd2} || {gnt, busy, res_valid, res_id, res} !== exp_out()) begin
            miscompares++;
            $display("FAIL abort_result actual=%h required=%h", {gnt, busy, res_valid, res_id, res}, exp_out());
        end
        req = 4'b0000;
        cycle();
    endtask

    task automatic test_random();
        logic prev_rv = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 39) != 0);
            req     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            op_flat = 8'($urandom);
            a_flat  = {$urandom, $urandom};
            b_flat  = {$urandom, $urandom};
            cycle();
            vectors++;
            if ({gnt, busy, res_valid, res_id, res} !== exp_out()) begin
                miscompares++;
                $display("FAIL random_model c=%0d actual=%h required=%h", c, {gnt, busy, res_valid, res_id, res}, exp_out());
            end
            vectors++;
            if (!$onehot0(gnt) || (prev_rv && res_valid)) begin
                miscompares++;
                $display("FAIL random_props c=%0d actual gnt=%b rv_pair=%b%b required onehot0 and no back-to-back valid", c, gnt, prev_rv, res_valid);
            end
            prev_rv = res_valid;
        end
        rst_n = 1'b1;
        req   = 4'b0000;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; req = 4'b0000; op_flat = 8'h00; a_flat = '0; b_flat = '0;
        m_phase = 0; m_ptr = 0; m_idx = 0; m_op = 0; m_a = 0; m_b = 0;
        m_res = 0; m_gnt = 0; m_rv = 0; m_rid = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_ops();
        test_rotation();
        test_skip();
        test_latch();
        test_reset_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
